// File: rtl/compositor_pkg.sv
// Shared types and helpers for the layered pixel compositor.
package compositor_pkg;

    localparam int unsigned MaxLayers = 16;

    typedef logic [7:0] rgb332_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    function automatic rgb24_t rgb332_expand(rgb332_t c);
        rgb24_t o;
        o.r = {c[7:5], c[7:5], c[7:6]};
        o.g = {c[4:2], c[4:2], c[4:3]};
        o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
        return o;
    endfunction

    // Lowest set bit among the first n bits; n when none is set.
    function automatic logic [4:0] priority_index(logic [MaxLayers-1:0] vec, int unsigned n);
        logic [4:0] idx;
        logic       found;
        idx   = 5'(n);
        found = 1'b0;
        for (int unsigned i = 0; i < MaxLayers; i++) begin
            if (!found && (i < n) && vec[i]) begin
                idx   = 5'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/layered_pixel_compositor_blink_timer.sv
// Frame counter and blink phase; the phase reported on a startOfFrame cycle is already the
// new frame's phase, so a whole frame (including its first pixel) shares one phase.
module blink_timer #(
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    output logic blinkPhase
);
    localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CntW-1:0] frameCnt;
    logic            phaseQ;
    logic            wrap;

    assign wrap = startOfFrame && (frameCnt == CntW'(BLINK_FRAMES - 1));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frameCnt <= '0;
            phaseQ   <= 1'b0;
        end else if (startOfFrame) begin
            if (wrap) begin
                frameCnt <= '0;
                phaseQ   <= ~phaseQ;
            end else begin
                frameCnt <= frameCnt + CntW'(1);
            end
        end
    end

    assign blinkPhase = wrap ? ~phaseQ : phaseQ;

endmodule

// File: rtl/layered_pixel_compositor.sv
// Two-stage priority compositor of NUM_LAYERS RGB332 layers over a background, with
// enable, colour key, blinking and per-frame collision reporting against layer 0.
module layered_pixel_compositor
    import compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS      = 4,
    parameter logic [7:0]  TRANSPARENT_RGB = 8'hFF,
    parameter int unsigned BLINK_FRAMES    = 16,
    parameter int unsigned IDX_W           = $clog2(NUM_LAYERS + 1)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    pixelValid,
    input  logic                    startOfFrame,
    input  logic [NUM_LAYERS-1:0]   layerReq,
    input  logic [NUM_LAYERS*8-1:0] layerRGB,
    input  logic [7:0]              backGroundRGB,
    input  logic [NUM_LAYERS-1:0]   layerEnable,
    input  logic [NUM_LAYERS-1:0]   blinkMask,
    output logic [7:0]              redOut,
    output logic [7:0]              greenOut,
    output logic [7:0]              blueOut,
    output logic                    pixelValidOut,
    output logic [IDX_W-1:0]        winnerLayer,
    output logic [NUM_LAYERS-1:0]   collisionFlags,
    output logic                    collisionPulse
);
    logic                    blinkPhase;
    logic [NUM_LAYERS-1:0]   eff;
    logic [NUM_LAYERS-1:0]   effS1;
    logic [NUM_LAYERS*8-1:0] rgbS1;
    rgb332_t                 bgS1;
    logic                    pvS1;
    logic                    sofS1;
    logic [4:0]              winIdx;
    logic [IDX_W-1:0]        winNext;
    rgb332_t                 selRGB;
    rgb332_t                 tmpRGB;
    logic [NUM_LAYERS-1:0]   collNow;
    logic [NUM_LAYERS-1:0]   collAcc;
    rgb24_t                  expanded;

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_blink_timer (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .blinkPhase   (blinkPhase)
    );

    always_comb begin
        eff = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            eff[i] = layerReq[i] & layerEnable[i] & (layerRGB[8*i +: 8] != TRANSPARENT_RGB)
                   & ~(blinkMask[i] & blinkPhase);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            effS1 <= '0;
            rgbS1 <= '0;
            bgS1  <= '0;
            pvS1  <= 1'b0;
            sofS1 <= 1'b0;
        end else begin
            effS1 <= eff;
            rgbS1 <= layerRGB;
            bgS1  <= backGroundRGB;
            pvS1  <= pixelValid;
            sofS1 <= startOfFrame;
        end
    end

    always_comb begin
        winIdx  = priority_index(MaxLayers'(effS1), NUM_LAYERS);
        winNext = IDX_W'(NUM_LAYERS);
        selRGB  = bgS1;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (winIdx == 5'(i)) begin
                winNext = IDX_W'(i);
                selRGB  = rgbS1[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tmpRGB        <= '0;
            winnerLayer   <= '0;
            pixelValidOut <= 1'b0;
        end else begin
            pixelValidOut <= pvS1;
            if (pvS1) begin
                tmpRGB      <= selRGB;
                winnerLayer <= winNext;
            end else begin
                tmpRGB      <= 8'h00;
                winnerLayer <= IDX_W'(NUM_LAYERS);
            end
        end
    end

    // Layer 0 never collides with itself, so bit 0 stays clear.
    always_comb begin
        collNow = '0;
        if (pvS1 && effS1[0]) begin
            collNow = effS1;
            collNow[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            collAcc        <= '0;
            collisionFlags <= '0;
            collisionPulse <= 1'b0;
        end else if (sofS1) begin
            collisionFlags <= collAcc;
            collisionPulse <= |collAcc;
            collAcc        <= collNow;
        end else begin
            collisionPulse <= 1'b0;
            collAcc        <= collAcc | collNow;
        end
    end

    assign expanded = rgb332_expand(tmpRGB);
    assign redOut   = expanded.r;
    assign greenOut = expanded.g;
    assign blueOut  = expanded.b;

endmodule

// File: tb/tb_layered_pixel_compositor.sv
// Randomised and directed scoreboard bench for layered_pixel_compositor.
module tb_layered_pixel_compositor;
    localparam int unsigned N  = 4;
    localparam int unsigned BF = 2;
    localparam int unsigned IW = 3;

    logic           clk = 1'b0;
    logic           resetN = 1'b0;
    logic           pixelValid = 1'b0;
    logic           startOfFrame = 1'b0;
    logic [N-1:0]   layerReq = '0;
    logic [N*8-1:0] layerRGB = '0;
    logic [7:0]     backGroundRGB = '0;
    logic [N-1:0]   layerEnable = '0;
    logic [N-1:0]   blinkMask = '0;
    logic [7:0]     redOut, greenOut, blueOut;
    logic           pixelValidOut;
    logic [IW-1:0]  winnerLayer;
    logic [N-1:0]   collisionFlags;
    logic           collisionPulse;

    layered_pixel_compositor #(
        .NUM_LAYERS      (N),
        .TRANSPARENT_RGB (8'hFF),
        .BLINK_FRAMES    (BF)
    ) dut (
        .clk            (clk),
        .resetN         (resetN),
        .pixelValid     (pixelValid),
        .startOfFrame   (startOfFrame),
        .layerReq       (layerReq),
        .layerRGB       (layerRGB),
        .backGroundRGB  (backGroundRGB),
        .layerEnable    (layerEnable),
        .blinkMask      (blinkMask),
        .redOut         (redOut),
        .greenOut       (greenOut),
        .blueOut        (blueOut),
        .pixelValidOut  (pixelValidOut),
        .winnerLayer    (winnerLayer),
        .collisionFlags (collisionFlags),
        .collisionPulse (collisionPulse)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned   due;
        logic [7:0]    r, g, b;
        logic [IW-1:0] win;
        logic          pv;
        logic [N-1:0]  flags;
        logic          pulse;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: frames seen since reset, collisions of the running frame,
    // and the flags last reported.
    int unsigned  sofCount = 0;
    logic [N-1:0] mAcc = '0;
    logic [N-1:0] mFlags = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(logic pv, logic sof, logic [N-1:0] req, logic [N*8-1:0] rgb,
                         logic [7:0] bg, logic [N-1:0] en, logic [N-1:0] bm);
        exp_t         e;
        logic [N-1:0] effv;
        logic [N-1:0] coll;
        logic         hidden;
        int           win;
        logic [7:0]   c;
        int unsigned  r3, g3, b2;
        @(posedge clk);
        #1;
        pixelValid    = pv;
        startOfFrame  = sof;
        layerReq      = req;
        layerRGB      = rgb;
        backGroundRGB = bg;
        layerEnable   = en;
        blinkMask     = bm;

        if (sof) sofCount++;
        hidden = ((sofCount / BF) % 2) == 1;
        for (int i = 0; i < N; i++)
            effv[i] = req[i] && en[i] && (rgb[8*i +: 8] != 8'hFF) && !(bm[i] && hidden);
        win = N;
        for (int i = N - 1; i >= 0; i--)
            if (effv[i]) win = i;
        if (!pv) begin
            win = N;
            c   = 8'h00;
        end else if (win == N) begin
            c = bg;
        end else begin
            c = rgb[8*win +: 8];
        end
        r3 = int'(c[7:5]);
        g3 = int'(c[4:2]);
        b2 = int'(c[1:0]);
        e.r   = 8'(r3 * 36 + r3 / 2);
        e.g   = 8'(g3 * 36 + g3 / 2);
        e.b   = 8'(b2 * 85);
        e.win = IW'(win);
        e.pv  = pv;

        coll = '0;
        for (int i = 1; i < N; i++)
            coll[i] = pv && effv[0] && effv[i];
        if (sof) begin
            e.pulse = |mAcc;
            mFlags  = mAcc;
            mAcc    = coll;
        end else begin
            e.pulse = 1'b0;
            mAcc    = mAcc | coll;
        end
        e.flags = mFlags;
        e.due   = cyc + 2;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check("rst_red", 32'(redOut), 0);
        check("rst_green", 32'(greenOut), 0);
        check("rst_blue", 32'(blueOut), 0);
        check("rst_winner", 32'(winnerLayer), 0);
        check("rst_pv", 32'(pixelValidOut), 0);
        check("rst_flags", 32'(collisionFlags), 0);
        check("rst_pulse", 32'(collisionPulse), 0);
        sbq.delete();
        sofCount     = 0;
        mAcc         = '0;
        mFlags       = '0;
        pixelValid   = 1'b0;
        startOfFrame = 1'b0;
        layerReq     = '0;
        repeat (3) @(posedge clk);
        #3;
        resetN = 1'b1;
    endtask

    function automatic logic [7:0] rand_px();
        return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                check("red", 32'(redOut), 32'(e.r));
                check("green", 32'(greenOut), 32'(e.g));
                check("blue", 32'(blueOut), 32'(e.b));
                check("winner", 32'(winnerLayer), 32'(e.win));
                check("pv_out", 32'(pixelValidOut), 32'(e.pv));
                check("coll_flags", 32'(collisionFlags), 32'(e.flags));
                check("coll_pulse", 32'(collisionPulse), 32'(e.pulse));
            end
        end
    end

    initial begin : stim
        logic [N*8-1:0] rgb;
        do_reset();

        // Priority and background
        drive(1, 1, 4'b0000, '0, 8'h03, 4'hF, 4'h0);
        drive(1, 0, 4'b1010, {8'h1C, 8'h00, 8'hE0, 8'h00}, 8'h03, 4'hF, 4'h0);
        drive(1, 0, 4'b0000, {8'h1C, 8'h00, 8'hE0, 8'h00}, 8'h03, 4'hF, 4'h0);
        // Transparency and enable
        drive(1, 0, 4'b0101, {8'h00, 8'h1C, 8'h00, 8'hFF}, 8'h03, 4'hF, 4'h0);
        drive(1, 0, 4'b0101, {8'h00, 8'h1C, 8'h00, 8'hFF}, 8'h03, 4'b1011, 4'h0);
        // Blank
        drive(0, 0, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hE0}, 8'h03, 4'hF, 4'h0);
        drive(1, 0, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h92}, 8'h03, 4'hF, 4'h0);

        // Collision in one frame, reported at the next, cleared the one after
        rgb = {8'h11, 8'h1C, 8'h22, 8'hE0};
        drive(1, 1, 4'b0001, rgb, 8'h03, 4'hF, 4'h0);
        drive(1, 0, 4'b0101, rgb, 8'h03, 4'hF, 4'h0);
        repeat (3) drive(1, 0, 4'b0001, rgb, 8'h03, 4'hF, 4'h0);
        drive(1, 1, 4'b0001, rgb, 8'h03, 4'hF, 4'h0);
        repeat (3) drive(1, 0, 4'b0100, rgb, 8'h03, 4'hF, 4'h0);
        drive(1, 1, 4'b0001, rgb, 8'h03, 4'hF, 4'h0);
        repeat (3) drive(1, 0, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);
        // Overlap on the startOfFrame pixel belongs to the new frame
        drive(1, 1, 4'b1001, rgb, 8'h03, 4'hF, 4'h0);
        repeat (3) drive(1, 0, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);
        drive(1, 1, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);
        repeat (3) drive(1, 0, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);
        drive(1, 1, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);
        repeat (3) drive(1, 0, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);

        // Blink: frame 0 precedes the first startOfFrame after reset
        do_reset();
        for (int f = 0; f < 6; f++) begin
            drive(1, f > 0, 4'b0001, rgb, 8'h03, 4'hF, 4'b0001);
            repeat (3) drive(1, 0, 4'b0001, rgb, 8'h03, 4'hF, 4'b0001);
        end

        // Reset mid-frame discards the accumulated collision
        drive(1, 1, 4'b0001, rgb, 8'h03, 4'hF, 4'h0);
        drive(1, 0, 4'b0011, rgb, 8'h03, 4'hF, 4'h0);
        drive(1, 0, 4'b0001, rgb, 8'h03, 4'hF, 4'h0);
        do_reset();
        repeat (3) drive(1, 0, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);
        drive(1, 1, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);
        repeat (3) drive(1, 0, 4'b0000, rgb, 8'h03, 4'hF, 4'h0);

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            rgb = {rand_px(), rand_px(), rand_px(), rand_px()};
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, 4'($urandom),
                  rgb, 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
                  ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
